// File: rtl/stream_window_sum.sv
`default_nettype none
// ============================================================================
// Module   : stream_window_sum
// Summary  : Sums each consecutive window of N stream elements and emits one
//            registered sum per window. Optional macro
//            STREAM_WINDOW_SUM_SATURATE_EN makes every add saturate.
// Revision : 1.0 - initial release
// ============================================================================
module stream_window_sum #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sIn,
    input  logic             sIn_valid,
    output logic             sIn_ready,
    output logic [WIDTH-1:0] sOut,
    output logic             sOut_valid,
    input  logic             sOut_ready
);

    localparam logic [7:0] c_LAST   = 8'(N - 1);
    localparam bit         c_SINGLE = (N == 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_EMIT  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [7:0]       r_cnt;
    logic [WIDTH-1:0] r_sout;
    logic             r_sout_valid;

    logic             w_beat;
    logic [WIDTH-1:0] w_sum;

    function automatic logic [WIDTH-1:0] f_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef STREAM_WINDOW_SUM_SATURATE_EN
        return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
`else
        return s[WIDTH-1:0];
`endif
    endfunction

    assign in_ready   = (r_state == S_IDLE);
    assign sOut       = r_sout;
    assign sOut_valid = r_sout_valid;
    assign w_beat     = sIn_valid && sIn_ready;
    assign w_sum      = f_add(r_acc, sIn);

    // In EMIT the input is only taken when the pending sum leaves this cycle.
    always_comb begin
        sIn_ready = 1'b0;
        case (r_state)
            S_ACCUM: sIn_ready = 1'b1;
            S_EMIT:  sIn_ready = sOut_ready;
            default: sIn_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_sout       <= '0;
            r_sout_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state <= S_ACCUM;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_ACCUM: begin
                    if (w_beat) begin
                        if (r_cnt == c_LAST) begin
                            r_sout       <= w_sum;
                            r_sout_valid <= 1'b1;
                            r_state      <= S_EMIT;
                        end else begin
                            r_acc <= w_sum;
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                S_EMIT: begin
                    if (sOut_ready) begin
                        if (w_beat && c_SINGLE) begin
                            // A one-element window is complete on its own beat.
                            r_sout <= sIn;
                        end else if (w_beat) begin
                            r_sout_valid <= 1'b0;
                            r_acc        <= sIn;
                            r_cnt        <= 8'd1;
                            r_state      <= S_ACCUM;
                        end else begin
                            r_sout_valid <= 1'b0;
                            r_acc        <= '0;
                            r_cnt        <= '0;
                            r_state      <= S_ACCUM;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_window_sum.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_window_sum
// Summary  : Directed self-checking bench for stream_window_sum (N=4 and N=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_window_sum;

    logic       clk = 1'b0;
    logic       nrst;

    logic       a_in_valid, a_in_ready, a_sIn_valid, a_sIn_ready;
    logic       a_sOut_valid, a_sOut_ready;
    logic [7:0] a_sIn, a_sOut;

    logic       b_in_valid, b_in_ready, b_sIn_valid, b_sIn_ready;
    logic       b_sOut_valid, b_sOut_ready;
    logic [7:0] b_sIn, b_sOut;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stream_window_sum #(.WIDTH(8), .N(4)) u_dut4 (
        .clk(clk), .nrst(nrst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .sIn(a_sIn), .sIn_valid(a_sIn_valid), .sIn_ready(a_sIn_ready),
        .sOut(a_sOut), .sOut_valid(a_sOut_valid), .sOut_ready(a_sOut_ready)
    );

    stream_window_sum #(.WIDTH(8), .N(1)) u_dut1 (
        .clk(clk), .nrst(nrst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .sIn(b_sIn), .sIn_valid(b_sIn_valid), .sIn_ready(b_sIn_ready),
        .sOut(b_sOut), .sOut_valid(b_sOut_valid), .sOut_ready(b_sOut_ready)
    );

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic sv, input logic [7:0] sd, input logic ordy);
        a_sIn_valid  = sv;
        a_sIn        = sd;
        a_sOut_ready = ordy;
        tick();
    endtask

    task automatic check_reset4(input string tag);
        check_val({tag, "_in_ready"},   32'(a_in_ready),   32'd1);
        check_val({tag, "_sIn_ready"},  32'(a_sIn_ready),  32'd0);
        check_val({tag, "_sOut_valid"}, 32'(a_sOut_valid), 32'd0);
        check_val({tag, "_sOut"},       32'(a_sOut),       32'd0);
    endtask

    logic [7:0] exp_ovf;

    initial begin
`ifdef STREAM_WINDOW_SUM_SATURATE_EN
        exp_ovf = 8'd255;
`else
        exp_ovf = 8'd144;
`endif
        nrst = 1'b0;
        a_in_valid = 0; a_sIn_valid = 0; a_sIn = 0; a_sOut_ready = 1;
        b_in_valid = 0; b_sIn_valid = 0; b_sIn = 0; b_sOut_ready = 1;
        tick();
        tick();
        check_reset4("reset");
        check_val("reset_b_in_ready", 32'(b_in_ready), 32'd1);
        nrst = 1'b1;

        // Basic window 1,2,3,4 -> 10, valid for exactly one cycle
        a_in_valid = 1; tick(); a_in_valid = 0;
        check_val("start_sIn_ready", 32'(a_sIn_ready), 32'd1);
        check_val("start_in_ready", 32'(a_in_ready), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            drive4(1, 8'(i), 1);
            check_val("basic_early_valid", 32'(a_sOut_valid), 32'd0);
        end
        drive4(1, 8'd4, 1);
        check_val("basic_valid", 32'(a_sOut_valid), 32'd1);
        check_val("basic_sum", 32'(a_sOut), 32'd10);
        drive4(0, 8'd0, 1);
        check_val("basic_valid_drop", 32'(a_sOut_valid), 32'd0);

        // Back-to-back 1..8 -> 10 then 26, four cycles apart
        for (int i = 0; i < 8; i++) begin
            a_sIn_valid = 1; a_sIn = 8'(i + 1); a_sOut_ready = 1;
            #1;
            check_val("b2b_sIn_ready", 32'(a_sIn_ready), 32'd1);
            tick();
            check_val("b2b_valid", 32'(a_sOut_valid), 32'((i == 3) || (i == 7)));
            if (i == 3) check_val("b2b_sum0", 32'(a_sOut), 32'd10);
            if (i == 7) check_val("b2b_sum1", 32'(a_sOut), 32'd26);
        end

        // Backpressure while holding 26; the offered 1 must be taken exactly once
        for (int i = 0; i < 3; i++) begin
            a_sIn_valid = 1; a_sIn = 8'd1; a_sOut_ready = 0;
            #1;
            check_val("bp_sIn_ready", 32'(a_sIn_ready), 32'd0);
            tick();
            check_val("bp_valid", 32'(a_sOut_valid), 32'd1);
            check_val("bp_sum", 32'(a_sOut), 32'd26);
        end
        drive4(1, 8'd1, 1);
        check_val("bp_release_valid", 32'(a_sOut_valid), 32'd0);
        drive4(1, 8'd2, 1);
        drive4(1, 8'd3, 1);
        drive4(1, 8'd4, 1);
        check_val("bp_resume_valid", 32'(a_sOut_valid), 32'd1);
        check_val("bp_resume_sum", 32'(a_sOut), 32'd10);
        drive4(0, 8'd0, 1);

        // Overflow: stall cycles interleaved must not disturb the sum
        drive4(1, 8'd100, 1);
        drive4(0, 8'd55, 1);
        drive4(1, 8'd100, 1);
        drive4(1, 8'd100, 1);
        drive4(0, 8'd77, 1);
        check_val("ovf_stall_valid", 32'(a_sOut_valid), 32'd0);
        drive4(1, 8'd100, 1);
        check_val("ovf_valid", 32'(a_sOut_valid), 32'd1);
        check_val("ovf_sum", 32'(a_sOut), 32'(exp_ovf));
        drive4(0, 8'd0, 1);

        // Reset mid-window, then a fresh start with in_valid ignored mid-run
        drive4(1, 8'd1, 1);
        drive4(1, 8'd2, 1);
        nrst = 1'b0;
        drive4(0, 8'd0, 1);
        nrst = 1'b1;
        check_reset4("midrst");
        a_in_valid = 1; tick();
        for (int i = 0; i < 4; i++) begin
            drive4(1, 8'd5, 1);
        end
        a_in_valid = 0;
        check_val("rst_new_valid", 32'(a_sOut_valid), 32'd1);
        check_val("rst_new_sum", 32'(a_sOut), 32'd20);

        // N=1: toggling sIn_valid, in_valid pulses ignored after start
        b_in_valid = 1; tick();
        check_val("n1_sIn_ready", 32'(b_sIn_ready), 32'd1);
        b_sIn_valid = 1; b_sIn = 8'd7; tick();
        check_val("n1_v7", 32'(b_sOut_valid), 32'd1);
        check_val("n1_s7", 32'(b_sOut), 32'd7);
        b_sIn_valid = 0; b_sIn = 8'd99; tick();
        check_val("n1_gap_valid", 32'(b_sOut_valid), 32'd0);
        check_val("n1_in_ready", 32'(b_in_ready), 32'd0);
        b_sIn_valid = 1; b_sIn = 8'd9; tick();
        check_val("n1_v9", 32'(b_sOut_valid), 32'd1);
        check_val("n1_s9", 32'(b_sOut), 32'd9);
        b_in_valid = 0;
        b_sIn_valid = 1; b_sIn = 8'd3; tick();
        check_val("n1_s3", 32'(b_sOut), 32'd3);
        b_sOut_ready = 0; b_sIn = 8'd4; tick();
        check_val("n1_hold", 32'(b_sOut), 32'd3);
        b_sOut_ready = 1; tick();
        check_val("n1_s4_valid", 32'(b_sOut_valid), 32'd1);
        check_val("n1_s4", 32'(b_sOut), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
